imm_gen_pipe: RTL and testbench
===============================

# imm_gen_pipe

Pipelined, parametrised immediate generator for the core decode stage. It accepts one 32-bit RISC-V instruction per cycle over a valid/ready handshake and classifies the format (I/S/B/U/J). It emits the sign-extended immediate at XLEN width through a registered output with a 2-entry skid buffer, and flags unsupported opcodes. It sits between fetch and the register-read stage, and also supports a synchronous flush and a saturating illegal-opcode counter.

## Interface
- XLEN, 64, immediate width; legal values 32 or 64.
- CNT_W, 16, width of illegal-opcode counter.
- i_Clk  in  1  clock, all logic on rising edge.
- i_Rst  in  1  reset, synchronous, active-high.
- i_Flush  in  1  synchronous pipeline clear; counter unaffected.
- i_Valid  in  1  upstream instruction valid.
- o_Ready  out  1  block can accept; registered.
- i_Instr  in  32  instruction word.
- o_Valid  out  1  output entry valid.
- i_Ready  in  1  downstream accepts output.
- o_Immediate  out  XLEN  sign-extended immediate.
- o_ImmType  out  3  0=NONE, 1=I, 2=S, 3=B, 4=U, 5=J.
- o_Illegal  out  1  opcode not in the supported set.
- o_IllegalCount  out  CNT_W  saturating count of accepted illegal instructions.

## Operation
- Opcode decode on i_Instr[6:0]:
  - I: 0000011, 0010011, 1100111, 0011011 (0011011 only when XLEN=64; when XLEN=32 it is illegal).
  - S: 0100011.
  - B: 1100011.
  - U: 0110111, 0010111.
  - J: 1101111.
  - Anything else: type NONE, immediate 0, o_Illegal=1.
- Immediate construction, always sign-extended from instr[31] to XLEN:
  - I: instr[31:20].
  - S: {instr[31:25], instr[11:7]}.
  - B: {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}.
  - U: {instr[31:12], 12'b0}.
  - J: {instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}.
- Shift-immediate forms get no special case; they are I-type. Masking shamt is downstream's job.
- Storage is an output register (OUT) plus a skid register (SKID); each holds {imm, type, illegal} and a valid bit.
- Accept happens when i_Valid && o_Ready.
- Accepted data goes to OUT if OUT is empty or is being consumed this cycle (o_Valid && i_Ready); otherwise it goes to SKID.
- When OUT is consumed and SKID is valid, SKID moves to OUT. A same-cycle accept then lands in SKID.
- o_Ready = !SKID.valid, registered, so there is no combinational i_Ready→o_Ready path.
- Ordering is strictly FIFO; no entry is dropped or duplicated.
- The counter increments on every accepted illegal instruction and saturates at 2^CNT_W−1.
- Flush clears both valid bits next cycle. An instruction presented in the flush cycle is discarded and is not counted.

## Timing
- Reset values:
  - o_Valid=0, o_Ready=1, o_Immediate=0, o_ImmType=0, o_Illegal=0, o_IllegalCount=0.
  - Both valid bits are cleared.
- Latency: accept at edge N, so o_Valid=1 with data after edge N; 1 cycle.
- Throughput: 1/cycle while i_Ready=1.
- Backpressure:
  - With i_Ready=0, the block holds at most 2 entries.
  - o_Ready drops the cycle after SKID fills, and rises the cycle after SKID drains.
- Output stability: o_Immediate, o_ImmType and o_Illegal hold stable while o_Valid && !i_Ready.
- Flush: i_Flush has priority over accept and drain. After a flush, o_Valid=0 and o_Ready=1 next cycle.
- Reset mid-transfer: reset overrides everything, including flush, and clears the counter.
- Data fields of an empty register are don't-care. The bench checks them only when o_Valid=1.

## Structure
- Shared package or include holds the imm-type encodings (IMM_NONE..IMM_J) and the opcode localparams (OP_LOAD, OP_IMM, OP_JALR, OP_IMM32, OP_STORE, OP_BRANCH, OP_LUI, OP_AUIPC, OP_JAL), for reuse by the main decoder.
- Sub-module imm_decode: combinational, takes instr and returns {imm, type, illegal}, parametrised by XLEN.
- imm_gen_pipe wraps imm_decode with the skid/output registers, flush logic and counter.

## Test plan
- XLEN=64, i_Ready=1: 0xFFF00093 → next cycle o_ImmType=1, o_Immediate=0xFFFFFFFFFFFFFFFF, o_Illegal=0.
- Stream back-to-back with i_Ready=1:
  - 0xFE112E23 → S, imm −4 (0xFFFF…FFFC).
  - 0xABCDE0B7 → U, 0xFFFFFFFFABCDE000.
  - 0x001000EF → J, 0x800.
  - Required: one result per cycle, in order.
- XLEN=32: 0xABCDE0B7 → 0xABCDE000. 0x0000001B → illegal, count +1.
- Backpressure: hold i_Ready=0 and present 3 instructions.
  - Two are accepted, and o_Ready=0 on the cycle after the second.
  - Output stays stable on the first.
  - After i_Ready=1, entries drain in order with no loss.
- Illegal/saturation, CNT_W=2: feed 0xFFFFFFFF and 0xABCDFFFF repeatedly.
  - Each gives imm=0, type=0, o_Illegal=1.
  - Counter goes 1, 2, 3, then stays 3.
- Flush and reset with 2 entries held:
  - i_Flush=1 → o_Valid=0 and o_Ready=1 next cycle; counter unchanged.
  - i_Rst=1 mid-stream → all outputs return to their reset values next cycle.

Source files
------------

// File: rtl/imm_gen_pipe_pkg.sv
// rtl/imm_gen_pipe_pkg.sv - immediate-type encodings and RISC-V opcodes shared by the decoders
package imm_gen_pipe_pkg;

    typedef enum logic [2:0] {
        IMM_NONE = 3'd0,
        IMM_I    = 3'd1,
        IMM_S    = 3'd2,
        IMM_B    = 3'd3,
        IMM_U    = 3'd4,
        IMM_J    = 3'd5
    } imm_type_e;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_IMM32  = 7'b0011011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

endpackage

// File: rtl/imm_gen_pipe_decode.sv
// rtl/imm_gen_pipe_decode.sv - combinational opcode classifier and sign-extended immediate builder
module imm_decode
    import imm_gen_pipe_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [31:0]     instr_i,
    output logic [XLEN-1:0] imm_o,
    output imm_type_e       type_o,
    output logic            illegal_o
);

    logic [31:0] imm32;

    always_comb begin
        imm32     = '0;
        type_o    = IMM_NONE;
        illegal_o = 1'b0;
        case (instr_i[6:0])
            OP_LOAD, OP_IMM, OP_JALR: type_o = IMM_I;
            // Word-sized ALU ops only exist on RV64.
            OP_IMM32: begin
                if (XLEN == 64) type_o = IMM_I;
                else            illegal_o = 1'b1;
            end
            OP_STORE:         type_o = IMM_S;
            OP_BRANCH:        type_o = IMM_B;
            OP_LUI, OP_AUIPC: type_o = IMM_U;
            OP_JAL:           type_o = IMM_J;
            default:          illegal_o = 1'b1;
        endcase

        case (type_o)
            IMM_I: imm32 = {{20{instr_i[31]}}, instr_i[31:20]};
            IMM_S: imm32 = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
            IMM_B: imm32 = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25],
                            instr_i[11:8], 1'b0};
            IMM_U: imm32 = {instr_i[31:12], 12'b0};
            IMM_J: imm32 = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20],
                            instr_i[30:21], 1'b0};
            default: imm32 = '0;
        endcase
    end

    assign imm_o = XLEN'($signed(imm32));

endmodule

// File: rtl/imm_gen_pipe.sv
// rtl/imm_gen_pipe.sv - immediate generator with output register, skid buffer, flush and illegal counter
module imm_gen_pipe
    import imm_gen_pipe_pkg::*;
#(
    parameter int XLEN  = 64,
    parameter int CNT_W = 16
) (
    input  logic             i_Clk,
    input  logic             i_Rst,
    input  logic             i_Flush,
    input  logic             i_Valid,
    output logic             o_Ready,
    input  logic [31:0]      i_Instr,
    output logic             o_Valid,
    input  logic             i_Ready,
    output logic [XLEN-1:0]  o_Immediate,
    output logic [2:0]       o_ImmType,
    output logic             o_Illegal,
    output logic [CNT_W-1:0] o_IllegalCount
);

    logic [XLEN-1:0]  dec_imm;
    imm_type_e        dec_type;
    logic             dec_ill;

    logic             out_valid_q, out_valid_d;
    logic [XLEN-1:0]  out_imm_q, out_imm_d;
    logic [2:0]       out_type_q, out_type_d;
    logic             out_ill_q, out_ill_d;
    logic             skid_valid_q, skid_valid_d;
    logic [XLEN-1:0]  skid_imm_q, skid_imm_d;
    logic [2:0]       skid_type_q, skid_type_d;
    logic             skid_ill_q, skid_ill_d;
    logic             ready_q, ready_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             accept, consume;

    imm_decode #(.XLEN(XLEN)) u_decode (
        .instr_i   (i_Instr),
        .imm_o     (dec_imm),
        .type_o    (dec_type),
        .illegal_o (dec_ill)
    );

    assign accept  = i_Valid && ready_q;
    assign consume = out_valid_q && i_Ready;

    always_comb begin
        out_valid_d  = out_valid_q;
        out_imm_d    = out_imm_q;
        out_type_d   = out_type_q;
        out_ill_d    = out_ill_q;
        skid_valid_d = skid_valid_q;
        skid_imm_d   = skid_imm_q;
        skid_type_d  = skid_type_q;
        skid_ill_d   = skid_ill_q;
        cnt_d        = cnt_q;

        if (consume) begin
            if (skid_valid_q) begin
                out_imm_d    = skid_imm_q;
                out_type_d   = skid_type_q;
                out_ill_d    = skid_ill_q;
                skid_valid_d = 1'b0;
            end else begin
                out_valid_d  = 1'b0;
            end
        end

        if (accept) begin
            if ((!out_valid_q || consume) && !skid_valid_q) begin
                out_valid_d  = 1'b1;
                out_imm_d    = dec_imm;
                out_type_d   = dec_type;
                out_ill_d    = dec_ill;
            end else begin
                skid_valid_d = 1'b1;
                skid_imm_d   = dec_imm;
                skid_type_d  = dec_type;
                skid_ill_d   = dec_ill;
            end
            if (dec_ill && cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + CNT_W'(1);
        end

        // Flush discards the in-flight instruction as well, so it is never counted.
        if (i_Flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
            cnt_d        = cnt_q;
        end

        ready_d = !skid_valid_d;
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            out_valid_q  <= 1'b0;
            out_imm_q    <= '0;
            out_type_q   <= '0;
            out_ill_q    <= 1'b0;
            skid_valid_q <= 1'b0;
            skid_imm_q   <= '0;
            skid_type_q  <= '0;
            skid_ill_q   <= 1'b0;
            ready_q      <= 1'b1;
            cnt_q        <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_imm_q    <= out_imm_d;
            out_type_q   <= out_type_d;
            out_ill_q    <= out_ill_d;
            skid_valid_q <= skid_valid_d;
            skid_imm_q   <= skid_imm_d;
            skid_type_q  <= skid_type_d;
            skid_ill_q   <= skid_ill_d;
            ready_q      <= ready_d;
            cnt_q        <= cnt_d;
        end
    end

    assign o_Ready        = ready_q;
    assign o_Valid        = out_valid_q;
    assign o_Immediate    = out_imm_q;
    assign o_ImmType      = out_type_q;
    assign o_Illegal      = out_ill_q;
    assign o_IllegalCount = cnt_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb/tb_imm_gen_pipe.sv - scoreboard bench driving an RV64 (2-bit counter) and an RV32 instance in lockstep
module tb_imm_gen_pipe;

    typedef struct {
        logic [63:0] imm;
        logic [2:0]  ty;
        logic        ill;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst, flush, vin, rdy;
    logic [31:0] instr;

    logic        r64, v64, il64;
    logic [63:0] imm64;
    logic [2:0]  ty64;
    logic [1:0]  cnt64;
    logic        r32, v32, il32;
    logic [31:0] imm32;
    logic [2:0]  ty32;
    logic [15:0] cnt32;

    int total = 0;
    int bad   = 0;
    exp_t q64[$];
    exp_t q32[$];

    logic [31:0] v_instr [12];
    logic [63:0] v_e64   [12];
    logic [63:0] v_e32   [12];
    logic [2:0]  v_t64   [12];
    logic [2:0]  v_t32   [12];
    logic        v_i64   [12];
    logic        v_i32   [12];

    always #5 clk = ~clk;

    imm_gen_pipe #(.XLEN(64), .CNT_W(2)) dut64 (
        .i_Clk(clk), .i_Rst(rst), .i_Flush(flush), .i_Valid(vin), .o_Ready(r64),
        .i_Instr(instr), .o_Valid(v64), .i_Ready(rdy), .o_Immediate(imm64),
        .o_ImmType(ty64), .o_Illegal(il64), .o_IllegalCount(cnt64)
    );

    imm_gen_pipe #(.XLEN(32), .CNT_W(16)) dut32 (
        .i_Clk(clk), .i_Rst(rst), .i_Flush(flush), .i_Valid(vin), .o_Ready(r32),
        .i_Instr(instr), .o_Valid(v32), .i_Ready(rdy), .o_Immediate(imm32),
        .o_ImmType(ty32), .o_Illegal(il32), .o_IllegalCount(cnt32)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin : mon64
        exp_t e;
        if (!rst && v64 && rdy) begin
            if (q64.size() == 0) chk("m64_unexpected", 64'd1, 64'd0);
            else begin
                e = q64.pop_front();
                chk("m64_imm", imm64, e.imm);
                chk("m64_type", {61'd0, ty64}, {61'd0, e.ty});
                chk("m64_ill", {63'd0, il64}, {63'd0, e.ill});
            end
        end
    end

    always @(negedge clk) begin : mon32
        exp_t e;
        if (!rst && v32 && rdy) begin
            if (q32.size() == 0) chk("m32_unexpected", 64'd1, 64'd0);
            else begin
                e = q32.pop_front();
                chk("m32_imm", {32'd0, imm32}, e.imm);
                chk("m32_type", {61'd0, ty32}, {61'd0, e.ty});
                chk("m32_ill", {63'd0, il32}, {63'd0, e.ill});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int i, output int waits);
        logic acc;
        logic done;
        waits = 0;
        done  = 1'b0;
        vin   = 1'b1;
        instr = v_instr[i];
        while (!done) begin
            @(negedge clk);
            acc = r64 && !flush;
            if (acc) q64.push_back('{v_e64[i], v_t64[i], v_i64[i]});
            if (r32 && !flush) q32.push_back('{v_e32[i], v_t32[i], v_i32[i]});
            tick();
            if (acc) done = 1'b1;
            else begin
                waits++;
                if (waits > 50) begin
                    chk("send_timeout", 64'd1, 64'd0);
                    done = 1'b1;
                end
            end
        end
        vin = 1'b0;
    endtask

    task automatic set_vec(input int i, input logic [31:0] ins, input logic [63:0] e64,
                           input logic [63:0] e32, input logic [2:0] t64, input logic [2:0] t32,
                           input logic i64, input logic i32);
        v_instr[i] = ins; v_e64[i] = e64; v_e32[i] = e32;
        v_t64[i] = t64; v_t32[i] = t32; v_i64[i] = i64; v_i32[i] = i32;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_valid64"}, {63'd0, v64}, 64'd0);
        chk({tag, "_ready64"}, {63'd0, r64}, 64'd1);
        chk({tag, "_imm64"}, imm64, 64'd0);
        chk({tag, "_type64"}, {61'd0, ty64}, 64'd0);
        chk({tag, "_ill64"}, {63'd0, il64}, 64'd0);
        chk({tag, "_cnt64"}, {62'd0, cnt64}, 64'd0);
        chk({tag, "_valid32"}, {63'd0, v32}, 64'd0);
        chk({tag, "_ready32"}, {63'd0, r32}, 64'd1);
        chk({tag, "_imm32"}, {32'd0, imm32}, 64'd0);
        chk({tag, "_cnt32"}, {48'd0, cnt32}, 64'd0);
    endtask

    initial begin
        int w;
        set_vec(0,  32'hFFF00093, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFF, 3'd1, 3'd1, 1'b0, 1'b0);
        set_vec(1,  32'hFE112E23, 64'hFFFFFFFFFFFFFFFC, 64'hFFFFFFFC, 3'd2, 3'd2, 1'b0, 1'b0);
        set_vec(2,  32'hABCDE0B7, 64'hFFFFFFFFABCDE000, 64'hABCDE000, 3'd4, 3'd4, 1'b0, 1'b0);
        set_vec(3,  32'h001000EF, 64'h800,              64'h800,      3'd5, 3'd5, 1'b0, 1'b0);
        set_vec(4,  32'h00000463, 64'h8,                64'h8,        3'd3, 3'd3, 1'b0, 1'b0);
        set_vec(5,  32'hFE000EE3, 64'hFFFFFFFFFFFFFFFC, 64'hFFFFFFFC, 3'd3, 3'd3, 1'b0, 1'b0);
        set_vec(6,  32'h12345017, 64'h12345000,         64'h12345000, 3'd4, 3'd4, 1'b0, 1'b0);
        set_vec(7,  32'h7FF00003, 64'h7FF,              64'h7FF,      3'd1, 3'd1, 1'b0, 1'b0);
        set_vec(8,  32'h80000067, 64'hFFFFFFFFFFFFF800, 64'hFFFFF800, 3'd1, 3'd1, 1'b0, 1'b0);
        set_vec(9,  32'h0000001B, 64'h0,                64'h0,        3'd1, 3'd0, 1'b0, 1'b1);
        set_vec(10, 32'hFFFFFFFF, 64'h0,                64'h0,        3'd0, 3'd0, 1'b1, 1'b1);
        set_vec(11, 32'hABCDFFFF, 64'h0,                64'h0,        3'd0, 3'd0, 1'b1, 1'b1);

        rst = 1'b1; flush = 1'b0; vin = 1'b0; rdy = 1'b1; instr = '0;
        repeat (3) tick();
        @(negedge clk);
        chk_reset_vals("rst");
        tick();
        rst = 1'b0;

        // Single instruction, one-cycle latency.
        send(0, w);
        @(negedge clk);
        chk("lat_valid", {63'd0, v64}, 64'd1);
        tick();

        // Back-to-back stream; each must be taken without a wait state.
        for (int i = 1; i <= 9; i++) begin
            send(i, w);
            chk($sformatf("stream_wait_%0d", i), w, 0);
        end
        repeat (2) tick();
        chk("cnt32_after_imm32", {48'd0, cnt32}, 64'd1);
        chk("cnt64_after_imm32", {62'd0, cnt64}, 64'd0);

        // Backpressure: two entries held, third stalls until drain.
        rdy = 1'b0;
        send(0, w);
        send(1, w);
        vin = 1'b1; instr = v_instr[2];
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("bp_ready", {63'd0, r64}, 64'd0);
            chk("bp_valid", {63'd0, v64}, 64'd1);
            chk("bp_hold_imm", imm64, v_e64[0]);
            chk("bp_hold_type", {61'd0, ty64}, 64'd1);
            tick();
        end
        rdy = 1'b1;
        send(2, w);
        repeat (4) tick();
        chk("bp_drained64", q64.size(), 0);
        chk("bp_drained32", q32.size(), 0);

        // Illegal opcodes: 2-bit counter saturates at 3.
        for (int k = 0; k < 5; k++) begin
            send(10 + (k % 2), w);
            chk($sformatf("sat_cnt64_%0d", k), {62'd0, cnt64}, (k + 1 > 3) ? 64'd3 : 64'(k + 1));
            chk($sformatf("sat_cnt32_%0d", k), {48'd0, cnt32}, 64'(k + 2));
        end
        repeat (3) tick();

        // Flush with two entries held; flushed illegal instruction is not counted.
        rdy = 1'b0;
        send(0, w);
        send(1, w);
        vin = 1'b1; instr = v_instr[10]; flush = 1'b1;
        tick();
        flush = 1'b0; vin = 1'b0;
        q64.delete(); q32.delete();
        @(negedge clk);
        chk("fl_valid", {63'd0, v64}, 64'd0);
        chk("fl_ready", {63'd0, r64}, 64'd1);
        chk("fl_cnt64", {62'd0, cnt64}, 64'd3);
        chk("fl_cnt32", {48'd0, cnt32}, 64'd6);
        tick();

        // Reset mid-stream overrides a simultaneous flush and accept.
        send(2, w);
        send(3, w);
        vin = 1'b1; instr = v_instr[11]; flush = 1'b1; rst = 1'b1;
        tick();
        rst = 1'b0; flush = 1'b0; vin = 1'b0;
        q64.delete(); q32.delete();
        @(negedge clk);
        chk_reset_vals("mid_rst");
        tick();

        rdy = 1'b1;
        send(3, w);
        send(10, w);
        chk("post_rst_cnt64", {62'd0, cnt64}, 64'd1);
        repeat (3) tick();
        chk("final_empty64", q64.size(), 0);
        chk("final_empty32", q32.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
